seq_compare: RTL and testbench

SEQ_COMPARE -- requirements
Module: seq_compare

---
 rtl/seq_cmp_pkg.sv | 32 +++
 rtl/cmp_chunk.sv | 34 +++
 rtl/seq_compare.sv | 162 ++++++++++++++++
 tb/tb_seq_compare.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/seq_cmp_pkg.sv
// seq_cmp_pkg
//   Shared types for the sequential comparator:
//     cmp_op_t   - compare mode encoding (EQ, LT, LE, NE)
//     state_t    - comparator FSM state (IDLE, SCAN, DONE)
//     cmp_result - maps the raw lt/eq flags onto the selected mode
package seq_cmp_pkg;

   typedef enum logic [1:0] {
      CMP_EQ = 2'b00,
      CMP_LT = 2'b01,
      CMP_LE = 2'b10,
      CMP_NE = 2'b11
   } cmp_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_SCAN = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   function automatic logic cmp_result(input cmp_op_t op, input logic lt, input logic eq);
      logic r;
      case (op)
         CMP_EQ:  r = eq;
         CMP_LT:  r = lt;
         CMP_LE:  r = lt | eq;
         default: r = ~eq;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/cmp_chunk.sv
// cmp_chunk
//   Purely combinational compare of one CHUNK-bit slice.
//   Ports:
//     a, b     (in)  CHUNK-bit slices of the two operands
//     flip_msb (in)  invert the top bit of both slices first (sign chunk of a
//                    two's-complement compare, which turns it into unsigned order)
//     lt       (out) a < b after the optional flip
//     eq       (out) a == b
module cmp_chunk #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             flip_msb,
   output logic             lt,
   output logic             eq
);

   logic [CHUNK-1:0] a_m;
   logic [CHUNK-1:0] b_m;

   always_comb begin
      a_m = a;
      b_m = b;
      if (flip_msb) begin
         a_m[CHUNK-1] = ~a[CHUNK-1];
         b_m[CHUNK-1] = ~b[CHUNK-1];
      end
   end

   assign lt = (a_m < b_m);
   assign eq = (a_m == b_m);

endmodule

// File: rtl/seq_compare.sv
// seq_compare
//   Multi-cycle magnitude/equality comparator. One CHUNK-bit slice is compared
//   per cycle, MSB chunk first. The first differing chunk decides the ordering.
//
//   Build option: define SEQ_CMP_EARLY_EXIT_EN to stop scanning at the first
//   differing chunk (latency 1..NCHUNK). Without it every request scans all
//   NCHUNK chunks (latency NCHUNK). Results are identical in both builds.
//
//   Handshakes: a transfer happens on a rising edge where valid && ready are
//   both 1. The producer holds its payload steady while valid is 1 and ready is
//   0; ready never depends combinationally on valid.
//
//   Ports:
//     clk, rst             clock, synchronous active-high reset
//     in_valid / in_ready  request handshake (in_ready is 1 only in IDLE)
//     in_a, in_b           operands (WIDTH bits)
//     in_op                00 EQ, 01 LT, 10 LE, 11 NE
//     in_signed            1: two's-complement compare, 0: unsigned
//     out_valid / out_ready response handshake; outputs hold while waiting
//     out_result           result of the selected mode
//     out_lt, out_eq       raw A<B and A==B flags
//     fsm_state            current FSM state, for observation
module seq_compare
   import seq_cmp_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [1:0]       in_op,
   input  logic             in_signed,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_result,
   output logic             out_lt,
   output logic             out_eq,
   output state_t           fsm_state
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

   generate
      if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_chunk
         $error("seq_compare: WIDTH must be an integer multiple of CHUNK");
      end
   endgenerate

   state_t           state;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   cmp_op_t          op_r;
   logic             signed_r;
   logic [IDX_W-1:0] idx;
   logic             decided;   // a differing chunk has already been seen
   logic             lt_acc;    // ordering from that first differing chunk

   // Current chunk select: shift the addressed chunk down to bit 0.
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             flip;
   logic             ch_lt;
   logic             ch_eq;

   assign a_sh = a_r >> (idx * CHUNK);
   assign b_sh = b_r >> (idx * CHUNK);
   // Only the MSB chunk carries the sign bit.
   assign flip = signed_r && (idx == LAST_IDX);

   cmp_chunk #(.CHUNK(CHUNK)) u_cmp_chunk (
      .a        (a_sh[CHUNK-1:0]),
      .b        (b_sh[CHUNK-1:0]),
      .flip_msb (flip),
      .lt       (ch_lt),
      .eq       (ch_eq)
   );

   // Flags as they stand after the current chunk. Once decided, later
   // chunks are ignored; ch_lt is 0 whenever the chunk is equal.
   logic fin_lt;
   logic fin_eq;
   logic scan_end;

   always_comb begin
      fin_lt = decided ? lt_acc : ch_lt;
      fin_eq = !decided && ch_eq;
`ifdef SEQ_CMP_EARLY_EXIT_EN
      scan_end = !ch_eq || (idx == '0);
`else
      scan_end = (idx == '0);
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         out_result <= 1'b0;
         out_lt     <= 1'b0;
         out_eq     <= 1'b0;
         a_r        <= '0;
         b_r        <= '0;
         op_r       <= CMP_EQ;
         signed_r   <= 1'b0;
         idx        <= '0;
         decided    <= 1'b0;
         lt_acc     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  a_r      <= in_a;
                  b_r      <= in_b;
                  op_r     <= cmp_op_t'(in_op);
                  signed_r <= in_signed;
                  idx      <= LAST_IDX;
                  decided  <= 1'b0;
                  lt_acc   <= 1'b0;
                  in_ready <= 1'b0;
                  state    <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (!decided && !ch_eq) begin
                  decided <= 1'b1;
                  lt_acc  <= ch_lt;
               end
               if (scan_end) begin
                  out_valid  <= 1'b1;
                  out_lt     <= fin_lt;
                  out_eq     <= fin_eq;
                  out_result <= cmp_result(op_r, fin_lt, fin_eq);
                  state      <= ST_DONE;
               end else begin
                  idx <= idx - 1'b1;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               state    <= ST_IDLE;
               in_ready <= 1'b1;
            end
         endcase
      end
   end

   assign fsm_state = state;

endmodule

// File: tb/tb_seq_compare.sv
// tb_seq_compare
//   Directed bench for seq_compare (WIDTH=16, CHUNK=4). Expected latency
//   depends on whether SEQ_CMP_EARLY_EXIT_EN is defined; flags do not.
module tb_seq_compare;
   import seq_cmp_pkg::*;

`ifdef SEQ_CMP_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_a;
   logic [15:0] in_b;
   logic [1:0]  in_op;
   logic        in_signed;
   logic        out_valid;
   logic        out_ready;
   logic        out_result;
   logic        out_lt;
   logic        out_eq;
   state_t      fsm_state;

   int checks   = 0;
   int failures = 0;

   // {k[7:0], result, lt, eq}
   logic [10:0] exp_q[$];

   seq_compare #(.WIDTH(16), .CHUNK(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_op      (in_op),
      .in_signed  (in_signed),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_lt     (out_lt),
      .out_eq     (out_eq),
      .fsm_state  (fsm_state)
   );

   // clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Present a request and complete the acceptance edge (bounded wait).
   task automatic accept(input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] op, input logic sgn);
      int n;
      @(negedge clk);
      in_a      = a;
      in_b      = b;
      in_op     = op;
      in_signed = sgn;
      in_valid  = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("accept_timeout", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic push_exp(input int k_early, input logic res, input logic lt, input logic eq);
      logic [7:0] k;
      k = EARLY ? 8'(k_early) : 8'd4;
      exp_q.push_back({k, res, lt, eq});
   endtask

   // Count edges from acceptance until out_valid, then check flags.
   task automatic wait_result(input string tag);
      logic [10:0] e;
      int cnt;
      e = exp_q.pop_front();
      cnt = 0;
      do begin
         @(posedge clk);
         #1 cnt++;
      end while (!out_valid && cnt < 20);
      check({tag, "_lat"},    cnt, {24'd0, e[10:3]});
      check({tag, "_valid"},  {31'd0, out_valid}, 32'd1);
      check({tag, "_result"}, {31'd0, out_result}, {31'd0, e[2]});
      check({tag, "_lt"},     {31'd0, out_lt}, {31'd0, e[1]});
      check({tag, "_eq"},     {31'd0, out_eq}, {31'd0, e[0]});
   endtask

   task automatic release_out(input string tag);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      check({tag, "_rel_valid"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_rel_ready"}, {31'd0, in_ready}, 32'd1);
      check({tag, "_rel_state"}, {30'd0, fsm_state}, {30'd0, ST_IDLE});
   endtask

   task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic [1:0] op, input logic sgn,
                      input int k_early, input logic res, input logic lt, input logic eq);
      push_exp(k_early, res, lt, eq);
      accept(a, b, op, sgn);
      wait_result(tag);
      release_out(tag);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_state"},  {30'd0, fsm_state}, {30'd0, ST_IDLE});
      check({tag, "_ready"},  {31'd0, in_ready}, 32'd1);
      check({tag, "_valid"},  {31'd0, out_valid}, 32'd0);
      check({tag, "_result"}, {31'd0, out_result}, 32'd0);
      check({tag, "_lt"},     {31'd0, out_lt}, 32'd0);
      check({tag, "_eq"},     {31'd0, out_eq}, 32'd0);
   endtask

   initial begin
      int seen;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_a = '0; in_b = '0; in_op = 2'b00; in_signed = 1'b0;
      repeat (3) @(posedge clk);
      #1 check_reset_vals("reset");
      @(negedge clk) rst = 1'b0;

      //   tag          a        b        op     sgn k_e res lt eq
      run("s_lt_ext",  16'h8000, 16'h7FFF, 2'b01, 1, 1, 1, 1, 0);
      run("u_lt_ext",  16'h8000, 16'h7FFF, 2'b01, 0, 1, 0, 0, 0);
      run("u_lt_ext2", 16'h7FFF, 16'h8000, 2'b01, 0, 1, 1, 1, 0);
      run("s_lt_ext2", 16'h7FFF, 16'h8000, 2'b01, 1, 1, 0, 0, 0);
      run("eq_same",   16'h1234, 16'h1234, 2'b00, 0, 4, 1, 0, 1);
      run("le_lsb",    16'h1233, 16'h1234, 2'b10, 0, 4, 1, 1, 0);
      run("ne_same",   16'h1234, 16'h1234, 2'b11, 0, 4, 0, 0, 1);
      run("s_le_neg",  16'hFFFF, 16'h0001, 2'b10, 1, 1, 1, 1, 0);
      run("u_le_neg",  16'hFFFF, 16'h0001, 2'b10, 0, 1, 0, 0, 0);
      run("s_eq_neg",  16'hFEDC, 16'hFEDC, 2'b00, 1, 4, 1, 0, 1);

      // Back-pressure: outputs must hold while out_ready stays low.
      push_exp(2, 1, 1, 0);
      accept(16'h00F0, 16'h0F00, 2'b11, 0);
      wait_result("bp");
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("bp_hold_valid",  {31'd0, out_valid}, 32'd1);
         check("bp_hold_result", {31'd0, out_result}, 32'd1);
         check("bp_hold_lt",     {31'd0, out_lt}, 32'd1);
         check("bp_hold_eq",     {31'd0, out_eq}, 32'd0);
         check("bp_hold_ready",  {31'd0, in_ready}, 32'd0);
      end
      release_out("bp");

      // Reset in the SCAN cycle right after acceptance.
      accept(16'h00F0, 16'h0F00, 2'b01, 0);
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1 check_reset_vals("scan_rst");
      @(negedge clk) rst = 1'b0;
      seen = 0;
      repeat (8) begin
         @(posedge clk);
         #1 if (out_valid) seen++;
      end
      check("scan_rst_no_valid", seen, 0);
      run("post_rst",  16'h00F0, 16'h0F00, 2'b01, 0, 2, 1, 1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global time bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
